// File: rtl/ula_arith.sv
// ula_arith: registered arithmetic/shift unit for the execute stage.
// One shared WIDTH-bit adder serves every arithmetic opcode. Single-bit shifts
// are handled separately. Result and Z/C/S/O flags are captured together so
// the flags always describe the result that sits beside them.
module ula_arith #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       OP,
   output logic [WIDTH-1:0] RESU,
   output logic             Z,
   output logic             C,
   output logic             S,
   output logic             O
);

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_ADDINC = 5'b00001;
   localparam logic [4:0] OP_PASS   = 5'b00010;
   localparam logic [4:0] OP_INC    = 5'b00011;
   localparam logic [4:0] OP_SUBDEC = 5'b00100;
   localparam logic [4:0] OP_SUB    = 5'b00101;
   localparam logic [4:0] OP_DEC    = 5'b00110;
   localparam logic [4:0] OP_LSL    = 5'b01000;
   localparam logic [4:0] OP_LSR    = 5'b01001;
   localparam logic [4:0] OP_ASR    = 5'b01010;

   logic [WIDTH-1:0] add_x;
   logic [WIDTH-1:0] add_y;
   logic             add_cin;
   logic             use_adder;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             add_c_msb;

   logic [WIDTH-1:0] resu_d, resu_q;
   logic             z_d, z_q;
   logic             c_d, c_q;
   logic             s_d, s_q;
   logic             o_d, o_q;

   // Adder operand selection: subtracts feed ~B, INC/DEC feed a constant.
   always_comb begin
      add_x     = A;
      add_y     = '0;
      add_cin   = 1'b0;
      use_adder = 1'b0;
      unique case (OP)
         OP_ADD: begin
            add_y     = B;
            use_adder = 1'b1;
         end
         OP_ADDINC: begin
            add_y     = B;
            add_cin   = 1'b1;
            use_adder = 1'b1;
         end
         OP_INC: begin
            add_cin   = 1'b1;
            use_adder = 1'b1;
         end
         OP_SUBDEC: begin
            add_y     = ~B;
            use_adder = 1'b1;
         end
         OP_SUB: begin
            add_y     = ~B;
            add_cin   = 1'b1;
            use_adder = 1'b1;
         end
         OP_DEC: begin
            add_y     = '1;
            use_adder = 1'b1;
         end
         default: begin
            add_y     = '0;
            use_adder = 1'b0;
         end
      endcase
   end

   // Shared adder; the carry into the MSB is recovered from the MSB sum bit
   // (sum = x ^ y ^ carry_in), which avoids a second partial adder.
   always_comb begin
      {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
      add_c_msb           = add_sum[WIDTH-1] ^ add_x[WIDTH-1] ^ add_y[WIDTH-1];
   end

   // Result and flag selection for the operation presented this cycle.
   always_comb begin
      resu_d = '0;
      c_d    = 1'b0;
      o_d    = 1'b0;
      if (use_adder) begin
         resu_d = add_sum;
         c_d    = add_cout;
         o_d    = add_c_msb ^ add_cout;
      end else begin
         unique case (OP)
            OP_PASS: begin
               resu_d = A;
            end
            OP_LSL: begin
               resu_d = {A[WIDTH-2:0], 1'b0};
               c_d    = A[WIDTH-1];
               o_d    = A[WIDTH-1] ^ A[WIDTH-2];
            end
            OP_LSR: begin
               resu_d = {1'b0, A[WIDTH-1:1]};
               c_d    = A[0];
            end
            OP_ASR: begin
               resu_d = {A[WIDTH-1], A[WIDTH-1:1]};
               c_d    = A[0];
            end
            default: begin
               resu_d = '0;
            end
         endcase
      end
      z_d = (resu_d == '0);
      s_d = resu_d[WIDTH-1];
   end

   // Output register; reset clears everything immediately, independent of CLK.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         resu_q <= '0;
         z_q    <= 1'b0;
         c_q    <= 1'b0;
         s_q    <= 1'b0;
         o_q    <= 1'b0;
      end else begin
         resu_q <= resu_d;
         z_q    <= z_d;
         c_q    <= c_d;
         s_q    <= s_d;
         o_q    <= o_d;
      end
   end

   assign RESU = resu_q;
   assign Z    = z_q;
   assign C    = c_q;
   assign S    = s_q;
   assign O    = o_q;

endmodule

// File: tb/tb_ula_arith.sv
// Bench for ula_arith at WIDTH=3: directed vectors with literal expectations,
// an exhaustive operand sweep, and an integer-arithmetic reference model
// compared against the outputs on every falling edge.
module tb_ula_arith;

   localparam int W    = 3;
   localparam int M    = 1 << W;
   localparam int HALF = M / 2;

   logic         CLK;
   logic         RST;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [4:0]   OP;
   logic [W-1:0] RESU;
   logic         Z, C, S, O;

   int n_tests;
   int n_fail;

   ula_arith #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .OP(OP),
      .RESU(RESU), .Z(Z), .C(C), .S(S), .O(O)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected outputs packed as {RESU, Z, C, S, O}.
   function automatic logic [W+3:0] pack(int res, bit c, bit o);
      logic [W-1:0] r;
      r = res[W-1:0];
      return {r, (res == 0), c, (res >= HALF), o};
   endfunction

   function automatic int to_signed(int v);
      return (v >= HALF) ? v - M : v;
   endfunction

   // x + y + cin on unsigned operands; overflow means the true signed sum
   // does not fit in W bits.
   function automatic logic [W+3:0] add_model(int x, int y, int cin);
      int total, ssum;
      total = x + y + cin;
      ssum  = to_signed(x) + to_signed(y) + cin;
      return pack(total % M, total >= M, (ssum < -HALF) || (ssum >= HALF));
   endfunction

   function automatic logic [W+3:0] model(int a, int b, int op);
      int sa;
      sa = to_signed(a);
      case (op)
         0:  return add_model(a, b, 0);
         1:  return add_model(a, b, 1);
         2:  return pack(a, 1'b0, 1'b0);
         3:  return add_model(a, 0, 1);
         4:  return add_model(a, M - 1 - b, 0);
         5:  return add_model(a, M - 1 - b, 1);
         6:  return add_model(a, M - 1, 0);
         8:  return pack((a * 2) % M, a >= HALF, (sa * 2 < -HALF) || (sa * 2 >= HALF));
         9:  return pack(a / 2, (a % 2) == 1, 1'b0);
         10: return pack(a / 2 + ((a >= HALF) ? HALF : 0), (a % 2) == 1, 1'b0);
         default: return pack(0, 1'b0, 1'b0);
      endcase
   endfunction

   // Reference register: what the outputs must hold after each edge.
   logic [W+3:0] mdl;
   always @(posedge CLK or posedge RST) begin
      if (RST) mdl <= '0;
      else     mdl <= model(int'(A), int'(B), int'(OP));
   end

   // Every falling edge: DUT outputs must equal the reference (zero in reset).
   always @(negedge CLK) begin
      n_tests++;
      if ({RESU, Z, C, S, O} !== mdl) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t op=%b a=%b b=%b got=%b want=%b",
                  $time, OP, A, B, {RESU, Z, C, S, O}, mdl);
      end
   end

   task automatic check(string name, logic [W+3:0] want);
      n_tests++;
      if ({RESU, Z, C, S, O} !== want) begin
         n_fail++;
         $display("FAIL %s got={RESU,Z,C,S,O}=%b want=%b", name, {RESU, Z, C, S, O}, want);
      end
   endtask

   // Drive at the falling edge, check one cycle after the capturing edge.
   task automatic apply(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b);
      @(negedge CLK);
      OP = op;
      A  = a;
      B  = b;
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      string        name;
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W+3:0] want;
   } vec_t;

   vec_t vecs[$];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      RST = 1'b1;
      A   = '0;
      B   = '0;
      OP  = '0;

      //            name          op        a       b       {RESU,Z,C,S,O}
      vecs.push_back('{"add_1_7",    5'b00000, 3'b001, 3'b111, 7'b000_1100});
      vecs.push_back('{"add_2_3",    5'b00000, 3'b010, 3'b011, 7'b101_0011});
      vecs.push_back('{"add_4_7",    5'b00000, 3'b100, 3'b111, 7'b011_0101});
      vecs.push_back('{"add_7_6",    5'b00000, 3'b111, 3'b110, 7'b101_0110});
      vecs.push_back('{"add_1_2",    5'b00000, 3'b001, 3'b010, 7'b011_0000});
      vecs.push_back('{"addinc_0_7", 5'b00001, 3'b000, 3'b111, 7'b000_1100});
      vecs.push_back('{"addinc_1_2", 5'b00001, 3'b001, 3'b010, 7'b100_0011});
      vecs.push_back('{"addinc_6_6", 5'b00001, 3'b110, 3'b110, 7'b101_0110});
      vecs.push_back('{"addinc_4_7", 5'b00001, 3'b100, 3'b111, 7'b100_0110});
      vecs.push_back('{"pass_5",     5'b00010, 3'b101, 3'b111, 7'b101_0010});
      vecs.push_back('{"inc_3",      5'b00011, 3'b011, 3'b000, 7'b100_0011});
      vecs.push_back('{"inc_7",      5'b00011, 3'b111, 3'b000, 7'b000_1100});
      vecs.push_back('{"subdec_6_5", 5'b00100, 3'b110, 3'b101, 7'b000_1100});
      vecs.push_back('{"subdec_3_1", 5'b00100, 3'b011, 3'b001, 7'b001_0100});
      vecs.push_back('{"subdec_6_2", 5'b00100, 3'b110, 3'b010, 7'b011_0101});
      vecs.push_back('{"sub_1_2",    5'b00101, 3'b001, 3'b010, 7'b111_0010});
      vecs.push_back('{"dec_0",      5'b00110, 3'b000, 3'b000, 7'b111_0010});
      vecs.push_back('{"lsl_3",      5'b01000, 3'b011, 3'b000, 7'b110_0011});
      vecs.push_back('{"asr_5",      5'b01010, 3'b101, 3'b000, 7'b110_0110});
      vecs.push_back('{"lsr_5",      5'b01001, 3'b101, 3'b000, 7'b010_0100});
      vecs.push_back('{"op_1f",      5'b11111, 3'b101, 3'b011, 7'b000_1000});
      vecs.push_back('{"op_07",      5'b00111, 3'b011, 3'b011, 7'b000_1000});

      repeat (2) @(posedge CLK);
      #1;
      check("reset_hold", 7'b000_0000);
      @(negedge CLK);
      RST = 1'b0;

      foreach (vecs[i]) begin
         apply(vecs[i].op, vecs[i].a, vecs[i].b);
         check(vecs[i].name, vecs[i].want);
      end

      // Inputs changing between edges must not disturb the held result.
      apply(5'b00000, 3'b010, 3'b011);
      A  = 3'b000;
      B  = 3'b000;
      OP = 5'b11111;
      #2;
      check("hold_between_edges", 7'b101_0011);

      // Asynchronous reset mid-cycle after a nonzero result.
      apply(5'b00000, 3'b010, 3'b011);
      #2;
      RST = 1'b1;
      #1;
      check("async_reset", 7'b000_0000);
      OP = 5'b00000;
      A  = 3'b010;
      B  = 3'b011;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_held", 7'b000_0000);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("release_no_edge", 7'b000_0000);
      @(posedge CLK);
      #1;
      check("first_capture", 7'b101_0011);

      // Sweep every operand pair for every decoded opcode plus an unused one.
      for (int op = 0; op <= 11; op++) begin
         for (int a = 0; a < M; a++) begin
            for (int b = 0; b < M; b++) begin
               @(negedge CLK);
               OP = 5'(op);
               A  = 3'(a);
               B  = 3'(b);
            end
         end
      end
      @(posedge CLK);
      @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ula_arith.md
# ula_arith

Registered arithmetic/shift unit for the datapath execute stage. It takes two signed WIDTH-bit operands and a 5-bit opcode, and produces a WIDTH-bit result plus Zero, Carry, Sign and Overflow flags. Result and flags are captured on the rising clock edge. Flag consumers (condition evaluation, branch logic) read them one cycle after the operands are presented.

## Interface
- WIDTH, default 32: operand and result width in bits; minimum 3; bench runs WIDTH=3.

- CLK  input  1  system clock, rising-edge active
- RST  input  1  reset, asynchronous, active-high
- A  input  WIDTH  operand A, two's complement
- B  input  WIDTH  operand B, two's complement
- OP  input  5  operation select
- RESU  output  WIDTH  registered result
- Z  output  1  registered zero flag
- C  output  1  registered carry / no-borrow flag
- S  output  1  registered sign flag
- O  output  1  registered signed-overflow flag

## Operation
- The core is one WIDTH-bit adder: sum = X + Y + cin, with cout taken from the adder.
- Opcodes:
  - 00000 ADD: X=A, Y=B, cin=0.
  - 00001 ADDINC: X=A, Y=B, cin=1 (A+B+1).
  - 00010 PASS: RESU=A, C=0, O=0.
  - 00011 INC: X=A, Y=0, cin=1.
  - 00100 SUBDEC: X=A, Y=~B, cin=0 (A-B-1).
  - 00101 SUB: X=A, Y=~B, cin=1.
  - 00110 DEC: X=A, Y=all-ones, cin=0.
  - 01000 LSL: RESU=A<<1, C=A[W-1], O=A[W-1]^A[W-2].
  - 01001 LSR: RESU=A>>1 with zero fill, C=A[0], O=0.
  - 01010 ASR: RESU=A>>>1 with sign fill, C=A[0], O=0.
  - Any other opcode: RESU=0, C=0, O=0.
- Adder ops:
  - C = carry out of bit W-1. For subtracts, C=1 means no borrow.
  - O = carry into bit W-1 XOR carry out of bit W-1.
- All ops:
  - Z = (RESU == 0).
  - S = RESU[W-1].
- Results wrap modulo 2^WIDTH. No saturation.

## Timing
- RESU, Z, C, S and O are flip-flops loaded on every rising CLK edge from the combinational function of the A/B/OP values at that edge.
- Latency is one cycle. A new operation is accepted every cycle. There is no handshake and no enable.
- RST asserted, at any time including mid-stream: all outputs go to 0 immediately, without waiting for a clock edge.
- While RST is high, outputs hold 0 regardless of clock.
- First capture occurs on the first rising edge after RST deasserts.
- A, B and OP changes between edges have no effect on the outputs.
- The flags always correspond to the same operation as RESU in the same cycle.

## Test plan
All scenarios use WIDTH=3, and each operation is checked one edge after it is applied.
- Reset: RST=1 asynchronously mid-cycle after a nonzero result -> RESU=000 and Z=C=S=O=0 without any clock edge; outputs hold 0 until release.
- ADD:
  - 001+111 -> RESU=000, Z=1, C=1, S=0, O=0.
  - 010+011 -> 101, O=1, S=1, C=0, Z=0.
  - 100+111 -> 011, O=1, C=1, S=0, Z=0.
  - 111+110 -> 101.
  - 001+010 -> 011.
- ADDINC:
  - 000+111 -> 000, Z=1, C=1, O=0.
  - 001+010 -> 100, O=1, S=1, C=0.
  - 110+110 -> 101, S=1, C=1, O=0.
  - 100+111 -> 100, S=1, C=1, O=0.
- INC:
  - A=011 -> 100, O=1, S=1, C=0.
  - A=111 -> 000, Z=1, C=1, O=0.
- SUBDEC:
  - 110,101 -> 000, Z=1, C=1.
  - 011,001 -> 001, C=1, O=0, S=0, Z=0.
  - 110,010 -> 011, O=1, C=1, S=0.
- SUB/DEC/shifts:
  - SUB 001,010 -> 111, S=1, C=0.
  - DEC 000 -> 111, C=0.
  - LSL 011 -> 110, O=1, C=0.
  - ASR 101 -> 110, C=1.
  - LSR 101 -> 010, C=1.
  - OP=11111 -> 000, Z=1.
